// File: rtl/regs.sv
// RV32I integer register file: x0 hardwired, combinational reads with optional
// same-cycle writeback bypass, and a pending-write scoreboard driving the decode stall.
module regs #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        issue_en_i,
  input  logic [4:0]  issue_addr_i,
  input  logic        reg_wen_i,
  input  logic [4:0]  wd_addr_i,
  input  logic [31:0] wd_data_i,
  output logic        stall_o
);

  logic [31:0] mem [32];
  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic        wb_vld;
  logic        iss_vld;
  logic        byp1;
  logic        byp2;

  assign wb_vld  = reg_wen_i && (wd_addr_i != 5'd0);
  assign iss_vld = issue_en_i && (issue_addr_i != 5'd0);
  assign byp1    = BYPASS_EN && reg_wen_i && (wd_addr_i == rs1_addr_i);
  assign byp2    = BYPASS_EN && reg_wen_i && (wd_addr_i == rs2_addr_i);

  always_comb begin
    rs1_data_o = 32'h0;
    if (rs1_addr_i != 5'd0) begin
      rs1_data_o = byp1 ? wd_data_i : mem[rs1_addr_i];
    end
  end

  always_comb begin
    rs2_data_o = 32'h0;
    if (rs2_addr_i != 5'd0) begin
      rs2_data_o = byp2 ? wd_data_i : mem[rs2_addr_i];
    end
  end

  assign stall_o = ((rs1_addr_i != 5'd0) && pending[rs1_addr_i] && !byp1) ||
                   ((rs2_addr_i != 5'd0) && pending[rs2_addr_i] && !byp2);

  // Clear before set: a same-address issue marks a newer write still in flight.
  always_comb begin
    pending_nxt = pending;
    if (wb_vld) begin
      pending_nxt[wd_addr_i] = 1'b0;
    end
    if (iss_vld) begin
      pending_nxt[issue_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (wb_vld) begin
      mem[wd_addr_i] <= wd_data_i;
    end
  end

endmodule

// File: tb/tb_regs.sv
// Scoreboard bench for regs: bypass and non-bypass instances share stimulus and are
// checked against an array-based register/pending model.
module tb_regs;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        reg_wen;
  logic [4:0]  wd_addr;
  logic [31:0] wd_data;
  logic [31:0] rs1_data_b, rs2_data_b, rs1_data_n, rs2_data_n;
  logic        stall_b, stall_n;

  regs #(.BYPASS_EN(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(rs1_data_b), .rs2_data_o(rs2_data_b),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr),
    .reg_wen_i(reg_wen), .wd_addr_i(wd_addr), .wd_data_i(wd_data),
    .stall_o(stall_b)
  );

  regs #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(rs1_data_n), .rs2_data_o(rs2_data_n),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr),
    .reg_wen_i(reg_wen), .wd_addr_i(wd_addr), .wd_data_i(wd_data),
    .stall_o(stall_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1b, d2b, d1n, d2n;
    logic        sb, sn;
    int          tag;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          phase = 0;
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s phase=%0d got=%h want=%h", name, tag, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs1_data_byp", e.tag, rs1_data_b, e.d1b);
      chk("rs2_data_byp", e.tag, rs2_data_b, e.d2b);
      chk("stall_byp",    e.tag, {31'h0, stall_b}, {31'h0, e.sb});
      chk("rs1_data_nb",  e.tag, rs1_data_n, e.d1n);
      chk("rs2_data_nb",  e.tag, rs2_data_n, e.d2n);
      chk("stall_nb",     e.tag, {31'h0, stall_n}, {31'h0, e.sn});
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && reg_wen && wd_addr == a) return wd_data;
    return m_regs[a];
  endfunction

  function automatic bit m_stall(input logic [4:0] a, input bit byp);
    return (a != 0) && m_pend[a] && !(byp && reg_wen && wd_addr == a);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
  endtask

  // mode 0: normal cycle, 1: reset held across the edge, 2: reset pulsed between edges
  task automatic cycle(input logic [4:0] r1, input logic [4:0] r2,
                       input logic ie, input logic [4:0] ia,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input int mode);
    exp_t e;
    rs1_addr = r1; rs2_addr = r2;
    issue_en = ie; issue_addr = ia;
    reg_wen = we; wd_addr = wa; wd_data = wd;
    if (mode != 0) begin
      rst_n = 1'b0;
      m_clear();
    end else begin
      rst_n = 1'b1;
    end
    e.d1b = m_read(r1, 1'b1);
    e.d2b = m_read(r2, 1'b1);
    e.sb  = m_stall(r1, 1'b1) || m_stall(r2, 1'b1);
    e.d1n = m_read(r1, 1'b0);
    e.d2n = m_read(r2, 1'b0);
    e.sn  = m_stall(r1, 1'b0) || m_stall(r2, 1'b0);
    e.tag = phase;
    q.push_back(e);
    if (mode == 2) begin
      @(negedge clk);
      #2 rst_n = 1'b1;
    end
    @(posedge clk);
    if (mode != 1) begin
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (ie && ia != 0) m_pend[ia] = 1'b1;
    end
    #1;
  endtask

  task automatic rand_cycle();
    cycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_addr = 0; rs2_addr = 0; issue_en = 0; issue_addr = 0;
    reg_wen = 0; wd_addr = 0; wd_data = 0;
    m_clear();
    @(posedge clk);
    #1;

    phase = 1;
    cycle(5'd1, 5'd2, 0, 0, 0, 0, 0, 1);
    cycle(5'd1, 5'd2, 0, 0, 0, 0, 0, 1);
    phase = 2;
    repeat (200) rand_cycle();
    phase = 3;
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i < 32; i++) cycle(5'(i), 5'(32 - i), 0, 0, 0, 0, 0, 0);

    phase = 4;
    cycle(5'd5, 5'd0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0);
    cycle(5'd0, 5'd5, 0, 0, 0, 0, 0, 0);

    phase = 5;
    cycle(5'd0, 5'd0, 1, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 0);
    cycle(5'd0, 5'd0, 0, 0, 0, 0, 0, 0);

    phase = 6;
    cycle(5'd0, 5'd0, 1, 5'd7, 0, 0, 0, 0);
    cycle(5'd0, 5'd7, 0, 0, 0, 0, 0, 0);
    cycle(5'd0, 5'd7, 0, 0, 0, 0, 0, 0);
    cycle(5'd0, 5'd7, 0, 0, 1, 5'd7, 32'h1234, 0);
    cycle(5'd0, 5'd7, 0, 0, 0, 0, 0, 0);

    phase = 7;
    cycle(5'd0, 5'd0, 1, 5'd9, 0, 0, 0, 0);
    cycle(5'd0, 5'd0, 1, 5'd9, 1, 5'd9, 32'h9999, 0);
    cycle(5'd9, 5'd0, 0, 0, 0, 0, 0, 0);

    phase = 8;
    cycle(5'd3, 5'd0, 1, 5'd3, 1, 5'd3, 32'hA5A5_A5A5, 0);
    cycle(5'd3, 5'd3, 0, 0, 0, 0, 0, 0);
    cycle(5'd3, 5'd3, 0, 0, 0, 0, 0, 2);
    cycle(5'd3, 5'd3, 0, 0, 0, 0, 0, 0);

    phase = 9;
    repeat (400) rand_cycle();

    rs1_addr = 0; rs2_addr = 0; issue_en = 0; reg_wen = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
